// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
//
// Datapath -> controller : op_i (opcode from IR), zero_i (ALU zero flag),
//                          mem_ready_i (memory access completes this cycle)
// Controller -> datapath : ALU/mux selects, memory/IR/PC/register strobes,
//                          illegal_o / mem_err_o event pulses, state_o debug
//
// The controller connects through the master modport; the datapath (or a
// testbench standing in for it) uses the slave modport.
interface multicycle_ctrl_if;
    logic [5:0] op_i;
    logic       zero_i;
    logic       mem_ready_i;

    logic [2:0] ALUOp_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic       IorD_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       PCWrite_o;
    logic [1:0] PCSource_o;
    logic       RegWrite_o;
    logic       RegDst_o;
    logic       MemtoReg_o;
    logic       illegal_o;
    logic       mem_err_o;
    logic [3:0] state_o;

    modport master (
        input  op_i, zero_i, mem_ready_i,
        output ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o,
               IRWrite_o, PCWrite_o, PCSource_o, RegWrite_o, RegDst_o,
               MemtoReg_o, illegal_o, mem_err_o, state_o
    );

    modport slave (
        output op_i, zero_i, mem_ready_i,
        input  ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o,
               IRWrite_o, PCWrite_o, PCSource_o, RegWrite_o, RegDst_o,
               MemtoReg_o, illegal_o, mem_err_o, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU. Sequences the shared ALU, the
// register file and the unified instruction/data memory over several cycles
// per instruction, waits on the memory ready handshake and optionally gives
// up on a memory access after WAIT_LIMIT waiting cycles.
//
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset; also forces all strobes low
//   bus    - multicycle_ctrl_if.master: opcode/zero/mem_ready in, datapath
//            controls, illegal/mem_err pulses and debug state out
//
// Parameters:
//   WAIT_LIMIT - max cycles waiting for mem_ready in one memory state (0 = forever)
//   CNT_W      - wait counter width, WAIT_LIMIT must be < 2**CNT_W
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam bit             LIMIT_EN = (WAIT_LIMIT != 0);
    // Count value seen on the WAIT_LIMIT-th waiting cycle (the count holds the
    // number of earlier waiting cycles).
    localparam logic [CNT_W-1:0] LIMIT_M1 =
        CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       waiting;
    logic       timeout;

    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       mem_err;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);

    // A ready arriving on the limit cycle wins, hence the mem_ready term.
    assign timeout = LIMIT_EN && waiting && !bus.mem_ready_i && (cnt_q == LIMIT_M1);

    // The counter only survives a cycle spent waiting; any exit (ready,
    // timeout, or a state that does not wait) clears it.
    always_comb begin
        cnt_d = '0;
        if (waiting && !bus.mem_ready_i && !timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        alu_op     = 3'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed by the ALU while the instruction is read.
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = 3'd3;
                if (bus.mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    mem_err  = 1'b1;
                    state_d  = S_FETCH;
                end
            end

            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = 2'd3;
                alu_op    = 3'd3;
                op_d      = bus.op_i;
                case (bus.op_i)
                    OP_R, OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI: state_d = S_EXEC;
                    OP_LW, OP_SW:                            state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                          state_d = S_BRANCH;
                    OP_J:                                    state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_EXEC: begin
                alu_src_a = 1'b1;
                if (op_q == OP_R) begin
                    alu_src_b = 2'd0;
                    alu_op    = 3'd0;
                end else begin
                    alu_src_b = 2'd2;
                    case (op_q)
                        OP_SLTIU: alu_op = 3'd4;
                        OP_ORI:   alu_op = 3'd5;
                        OP_LUI:   alu_op = 3'd6;
                        default:  alu_op = 3'd3;
                    endcase
                end
                state_d = S_ALU_WB;
            end

            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (op_q == OP_R);
                state_d   = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = 3'd3;
                if (op_q == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (op_q == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready_i) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.mem_ready_i) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd0;
                pc_source = 2'd1;
                if (op_q == OP_BNE) begin
                    alu_op   = 3'd2;
                    pc_write = !bus.zero_i;
                end else begin
                    alu_op   = 3'd1;
                    pc_write = bus.zero_i;
                end
                state_d = S_FETCH;
            end

            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                state_d   = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase

        // Strobes are gated by reset in the same cycle so nothing is written
        // or requested while the machine is being reset.
        if (rst_i) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
            mem_err   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ALUOp_o    = alu_op;
    assign bus.ALUSrcA_o  = alu_src_a;
    assign bus.ALUSrcB_o  = alu_src_b;
    assign bus.IorD_o     = iord;
    assign bus.MemRead_o  = mem_read;
    assign bus.MemWrite_o = mem_write;
    assign bus.IRWrite_o  = ir_write;
    assign bus.PCWrite_o  = pc_write;
    assign bus.PCSource_o = pc_source;
    assign bus.RegWrite_o = reg_write;
    assign bus.RegDst_o   = reg_dst;
    assign bus.MemtoReg_o = mem_to_reg;
    assign bus.illegal_o  = illegal;
    assign bus.mem_err_o  = mem_err;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: a WAIT_LIMIT=4 instance and a WAIT_LIMIT=0
// instance share the same stimulus. Covers a vector table, hand-written
// multi-cycle sequences and a randomized run against an instruction-level model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       rdy;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl_if if4();
    multicycle_ctrl_if if0();

    assign if4.op_i        = op;
    assign if4.zero_i      = zero;
    assign if4.mem_ready_i = rdy;
    assign if0.op_i        = op;
    assign if0.zero_i      = zero;
    assign if0.mem_ready_i = rdy;

    multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(8)) dut4 (.clk_i(clk), .rst_i(rst), .bus(if4));
    multicycle_ctrl #(.WAIT_LIMIT(0), .CNT_W(8)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));

    always #5 clk = ~clk;

    // Packed view: [21:18] state [17:15] ALUOp [14] SrcA [13:12] SrcB [11] IorD
    // [10] MemRead [9] MemWrite [8] IRWrite [7] PCWrite [6:5] PCSource
    // [4] RegWrite [3] RegDst [2] MemtoReg [1] illegal [0] mem_err
    logic [21:0] out4, out0;
    assign out4 = {if4.state_o, if4.ALUOp_o, if4.ALUSrcA_o, if4.ALUSrcB_o, if4.IorD_o,
                   if4.MemRead_o, if4.MemWrite_o, if4.IRWrite_o, if4.PCWrite_o,
                   if4.PCSource_o, if4.RegWrite_o, if4.RegDst_o, if4.MemtoReg_o,
                   if4.illegal_o, if4.mem_err_o};
    assign out0 = {if0.state_o, if0.ALUOp_o, if0.ALUSrcA_o, if0.ALUSrcB_o, if0.IorD_o,
                   if0.MemRead_o, if0.MemWrite_o, if0.IRWrite_o, if0.PCWrite_o,
                   if0.PCSource_o, if0.RegWrite_o, if0.RegDst_o, if0.MemtoReg_o,
                   if0.illegal_o, if0.mem_err_o};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] o, input logic z, input logic rd);
        rst  = r;
        op   = o;
        zero = z;
        rdy  = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- Vector table ----------------
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       rdy;
        logic [3:0] st;
        logic [2:0] alu;
        logic [1:0] srcb;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       regw;
        logic       regdst;
        logic       ill;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [5:0] o, input logic z,
                                input logic rd, input logic [3:0] st, input logic [2:0] alu,
                                input logic [1:0] srcb, input logic pcw,
                                input logic [1:0] pcsrc, input logic regw,
                                input logic regdst, input logic ill);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.st = st; v.alu = alu;
        v.srcb = srcb; v.pcw = pcw; v.pcsrc = pcsrc; v.regw = regw;
        v.regdst = regdst; v.ill = ill;
        return v;
    endfunction

    vec_t tbl[32];

    // ---------------- Reference model ----------------
    // Each instruction is a recipe of states run after DECODE; wait states
    // stall on memory readiness and abort to FETCH after `limit` waiting cycles.
    int m_st[2], m_opq[2], m_cnt[2], m_k[2];
    int lim[2];

    function automatic bit is_known(input logic [5:0] o);
        return o inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0B, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    endfunction

    function automatic int plan_step(input int o, input int k);
        int recipe_alu[2] = '{6, 7};
        int recipe_lw[3]  = '{2, 3, 4};
        int recipe_sw[2]  = '{2, 5};
        case (o)
            'h00, 'h08, 'h0B, 'h0D, 'h0F: return (k < 2) ? recipe_alu[k] : -1;
            'h23:                         return (k < 3) ? recipe_lw[k]  : -1;
            'h2B:                         return (k < 2) ? recipe_sw[k]  : -1;
            'h04, 'h05:                   return (k == 0) ? 8 : -1;
            'h02:                         return (k == 0) ? 9 : -1;
            default:                      return -1;
        endcase
    endfunction

    function automatic logic [21:0] mexp(input int id, input logic r, input logic [5:0] o,
                                         input logic z, input logic rd);
        logic [2:0] alu; logic sa; logic [1:0] sb; logic iord, mr, mw, irw, pcw;
        logic [1:0] ps; logic rw, rdst, m2r, ill, err;
        int s;
        s = m_st[id];
        alu = 0; sa = 0; sb = 0; iord = 0; mr = 0; mw = 0; irw = 0; pcw = 0;
        ps = 0; rw = 0; rdst = 0; m2r = 0; ill = 0; err = 0;
        err = (s == 0 || s == 3 || s == 5) && !rd && lim[id] != 0 && (m_cnt[id] + 1 == lim[id]);
        case (s)
            0: begin mr = 1; sb = 1; alu = 3; irw = rd; pcw = rd; end
            1: begin sb = 3; alu = 3; ill = !is_known(o); end
            2: begin sa = 1; sb = 2; alu = 3; end
            3: begin mr = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; iord = 1; end
            6: begin
                sa = 1;
                if (m_opq[id] == 'h00) begin sb = 0; alu = 0; end
                else begin
                    sb = 2;
                    alu = (m_opq[id] == 'h0B) ? 3'd4 : (m_opq[id] == 'h0D) ? 3'd5 :
                          (m_opq[id] == 'h0F) ? 3'd6 : 3'd3;
                end
            end
            7: begin rw = 1; rdst = (m_opq[id] == 'h00); end
            8: begin
                sa = 1; ps = 1;
                if (m_opq[id] == 'h05) begin alu = 2; pcw = !z; end
                else begin alu = 1; pcw = z; end
            end
            9: begin pcw = 1; ps = 2; end
            default: ;
        endcase
        if (r) begin mr = 0; mw = 0; irw = 0; pcw = 0; rw = 0; ill = 0; err = 0; end
        return {4'(s), alu, sa, sb, iord, mr, mw, irw, pcw, ps, rw, rdst, m2r, ill, err};
    endfunction

    task automatic madvance(input int id);
        int nxt;
        m_k[id]++;
        nxt = plan_step(m_opq[id], m_k[id]);
        m_st[id] = (nxt < 0) ? 0 : nxt;
    endtask

    task automatic mstep(input int id, input logic r, input logic [5:0] o, input logic rd);
        int s, nxt;
        s = m_st[id];
        if (r) begin
            m_st[id] = 0; m_cnt[id] = 0; m_opq[id] = 0;
        end else if (s == 0 || s == 3 || s == 5) begin
            if (rd) begin
                m_cnt[id] = 0;
                if (s == 0) m_st[id] = 1;
                else madvance(id);
            end else if (lim[id] != 0 && m_cnt[id] + 1 == lim[id]) begin
                m_cnt[id] = 0;
                m_st[id] = 0;
            end else begin
                m_cnt[id]++;
            end
        end else if (s == 1) begin
            m_opq[id] = int'(o);
            m_k[id] = 0;
            nxt = plan_step(m_opq[id], 0);
            m_st[id] = (nxt < 0) ? 0 : nxt;
        end else begin
            madvance(id);
        end
    endtask

    logic [5:0] legal[10];

    initial begin
        logic [14:0] act_v, exp_v;
        int pct;
        int pcts[3];
        logic r, z, rd;
        logic [5:0] o;

        legal = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0B, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        pcts  = '{90, 50, 20};
        lim   = '{4, 0};

        //        rst op    z  rdy  st alu sb pcw ps rw rd ill
        tbl[0]  = mk(1, 6'h00, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 6'h00, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 6'h00, 0, 1, 1, 3, 3, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 6'h00, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 6'h00, 0, 1, 7, 0, 0, 0, 0, 1, 1, 0);
        tbl[5]  = mk(0, 6'h04, 1, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 6'h04, 1, 1, 1, 3, 3, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 6'h04, 1, 1, 8, 1, 0, 1, 1, 0, 0, 0);
        tbl[8]  = mk(0, 6'h05, 1, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 6'h05, 1, 1, 1, 3, 3, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 6'h05, 1, 1, 8, 2, 0, 0, 1, 0, 0, 0);
        tbl[11] = mk(0, 6'h0D, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 6'h0D, 0, 1, 1, 3, 3, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 6'h0D, 0, 1, 6, 5, 2, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 6'h0D, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0);
        tbl[15] = mk(0, 6'h0F, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[16] = mk(0, 6'h0F, 0, 1, 1, 3, 3, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 6'h0F, 0, 1, 6, 6, 2, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 6'h0F, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0);
        tbl[19] = mk(0, 6'h3F, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[20] = mk(0, 6'h3F, 0, 1, 1, 3, 3, 0, 0, 0, 0, 1);
        tbl[21] = mk(0, 6'h02, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[22] = mk(0, 6'h02, 0, 1, 1, 3, 3, 0, 0, 0, 0, 0);
        tbl[23] = mk(0, 6'h02, 0, 1, 9, 0, 0, 1, 2, 0, 0, 0);
        tbl[24] = mk(0, 6'h08, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[25] = mk(0, 6'h08, 0, 1, 1, 3, 3, 0, 0, 0, 0, 0);
        tbl[26] = mk(0, 6'h08, 0, 1, 6, 3, 2, 0, 0, 0, 0, 0);
        tbl[27] = mk(0, 6'h08, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0);
        tbl[28] = mk(0, 6'h0B, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0);
        tbl[29] = mk(0, 6'h0B, 0, 1, 1, 3, 3, 0, 0, 0, 0, 0);
        tbl[30] = mk(0, 6'h0B, 0, 1, 6, 4, 2, 0, 0, 0, 0, 0);
        tbl[31] = mk(0, 6'h0B, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0);

        rst = 1'b1; op = 6'h00; zero = 1'b0; rdy = 1'b0;
        @(negedge clk);
        tick();

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].zero, tbl[i].rdy);
            act_v = {out4[21:18], out4[17:15], out4[13:12], out4[7], out4[6:5],
                     out4[4], out4[3], out4[1]};
            exp_v = {tbl[i].st, tbl[i].alu, tbl[i].srcb, tbl[i].pcw, tbl[i].pcsrc,
                     tbl[i].regw, tbl[i].regdst, tbl[i].ill};
            check($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
            tick();
        end

        // lw with three wait cycles in MEM_RD (ready lands on the limit cycle)
        drive(0, 6'h23, 0, 1); check("lw_fetch", 32'(out4[21:18]), 32'd0); tick();
        drive(0, 6'h23, 0, 1); check("lw_decode", 32'(out4[21:18]), 32'd1); tick();
        drive(0, 6'h23, 0, 0);
        check("lw_addr", 32'({out4[21:18], out4[14], out4[13:12]}), 32'({4'd2, 1'b1, 2'd2}));
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'h23, 0, (i == 3));
            check($sformatf("lw_rd%0d", i), 32'({out4[21:18], out4[11], out4[10], out4[0]}),
                  32'({4'd3, 1'b1, 1'b1, 1'b0}));
            tick();
        end
        drive(0, 6'h23, 0, 1);
        check("lw_wb", 32'({out4[21:18], out4[4], out4[3], out4[2]}), 32'({4'd4, 1'b1, 1'b0, 1'b1}));
        tick();

        // sw with memory never ready: limit-4 instance times out, limit-0 waits
        drive(0, 6'h2B, 0, 1); check("sw_fetch", 32'(out4[21:18]), 32'd0); tick();
        drive(0, 6'h2B, 0, 1); check("sw_decode", 32'(out4[21:18]), 32'd1); tick();
        drive(0, 6'h2B, 0, 1); check("sw_addr", 32'(out4[21:18]), 32'd2); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'h2B, 0, 0);
            check($sformatf("sw4_wr%0d", i), 32'({out4[21:18], out4[9], out4[11], out4[0]}),
                  32'({4'd5, 1'b1, 1'b1, (i == 3)}));
            check($sformatf("sw0_wr%0d", i), 32'({out0[21:18], out0[9], out0[0]}),
                  32'({4'd5, 1'b1, 1'b0}));
            tick();
        end
        drive(0, 6'h2B, 0, 0);
        check("sw4_after", 32'({out4[21:18], out4[10], out4[0]}), 32'({4'd0, 1'b1, 1'b0}));
        check("sw0_still", 32'({out0[21:18], out0[0]}), 32'({4'd5, 1'b0}));
        tick();

        // Reset during a FETCH wait (limit-4) and a MEM_WR wait (limit-0)
        drive(1, 6'h00, 0, 0);
        check("rst_memread", 32'({out4[10], out4[8], out4[7]}), 32'd0);
        check("rst_memwrite", 32'(out0[9]), 32'd0);
        tick();
        // FETCH timeout on the 4th waiting cycle, counter cleared afterwards
        for (int i = 0; i < 5; i++) begin
            drive(0, 6'h00, 0, 0);
            check($sformatf("fetch4_w%0d", i),
                  32'({out4[21:18], out4[10], out4[8], out4[7], out4[0]}),
                  32'({4'd0, 1'b1, 1'b0, 1'b0, (i == 3)}));
            check($sformatf("fetch0_w%0d", i), 32'({out0[21:18], out0[0]}), 32'({4'd0, 1'b0}));
            tick();
        end

        // Randomized run against the model
        drive(1, 6'h00, 0, 1);
        tick();
        for (int id = 0; id < 2; id++) begin
            m_st[id] = 0; m_cnt[id] = 0; m_opq[id] = 0; m_k[id] = 0;
        end
        pct = 90;
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 0) pct = pcts[(c / 250) % 3];
            r  = ($urandom_range(0, 63) == 0);
            o  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 9)];
            z  = 1'($urandom);
            rd = ($urandom_range(0, 99) < pct);
            drive(r, o, z, rd);
            check($sformatf("rnd4_c%0d", c), 32'(out4), 32'(mexp(0, r, o, z, rd)));
            check($sformatf("rnd0_c%0d", c), 32'(out0), 32'(mexp(1, r, o, z, rd)));
            mstep(0, r, o, rd);
            mstep(1, r, o, rd);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle version of the CPU. It sequences a single shared ALU, the register file and a unified instruction/data memory across several cycles per instruction.
- Drives the 3-bit ALUOp into the ALU controller using the existing encoding: 0 R-type, 1 beq, 2 bne, 3 add (addi/address/PC), 4 sltiu, 5 ori, 6 lui.
- Handles the memory ready handshake and an optional memory-wait timeout.

Parameters:
WAIT_LIMIT, 0, max cycles spent waiting for mem_ready_i in one memory state; 0 = wait forever.
CNT_W, 8, width of the wait counter; WAIT_LIMIT must be < 2**CNT_W.

Ports:
clk_i  in  1  clock, all state changes on rising edge
rst_i  in  1  synchronous, active-high reset
op_i  in  6  opcode from instruction register, valid in DECODE
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory access completes this cycle
ALUOp_o  out  3  to ALU controller
ALUSrcA_o  out  1  0 = PC, 1 = rs
ALUSrcB_o  out  2  0 = rt, 1 = const 4, 2 = sext imm, 3 = sext imm<<2
IorD_o  out  1  0 = PC address, 1 = ALUOut address
MemRead_o  out  1  memory read strobe
MemWrite_o  out  1  memory write strobe
IRWrite_o  out  1  load instruction register
PCWrite_o  out  1  load PC
PCSource_o  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
RegWrite_o  out  1  register file write
RegDst_o  out  1  0 = rt, 1 = rd
MemtoReg_o  out  1  0 = ALUOut, 1 = MDR
illegal_o  out  1  unrecognised opcode, 1-cycle pulse
mem_err_o  out  1  memory timeout, 1-cycle pulse
state_o  out  4  current state, for debug

Behaviour:
- Opcodes: R 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, sltiu 0x0B, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, ALU_WB 7, BRANCH 8, JUMP 9. Any other value goes to FETCH.
- Outputs are combinational from state and op_q. Any output not listed for a state is 0.
- op_q is registered from op_i on the DECODE cycle and is used in every state after DECODE.
- Reset:
  - Next state = FETCH; op_q = 0; wait counter = 0.
  - While rst_i = 1, all strobes are forced to 0 in the same cycle: MemRead, MemWrite, IRWrite, PCWrite, RegWrite, illegal, mem_err.
  - Reset mid-wait abandons the memory access.
- FETCH:
  - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ALUOp = 3.
  - If mem_ready_i = 1: IRWrite = 1, PCWrite = 1, PCSource = 0, next state DECODE. Otherwise stay.
- DECODE:
  - Outputs: ALUSrcA = 0, ALUSrcB = 3, ALUOp = 3 (branch target into ALUOut).
  - Next state: R/addi/sltiu/ori/lui → EXEC; lw/sw → MEM_ADDR; beq/bne → BRANCH; j → JUMP.
  - Unknown opcode: illegal_o = 1 this cycle, next state FETCH.
- EXEC:
  - ALUSrcA = 1.
  - R-type: ALUSrcB = 0, ALUOp = 0.
  - I-type: ALUSrcB = 2, ALUOp = 3 addi, 4 sltiu, 5 ori, 6 lui.
  - Next state ALU_WB.
- ALU_WB: RegWrite = 1, RegDst = 1 for R-type and 0 otherwise, MemtoReg = 0. Next state FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 2, ALUOp = 3. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead = 1, IorD = 1. On mem_ready_i go to MEM_WB.
- MEM_WB: RegWrite = 1, RegDst = 0, MemtoReg = 1. Next state FETCH.
- MEM_WR: MemWrite = 1, IorD = 1. On mem_ready_i go to FETCH.
- BRANCH:
  - Outputs: ALUSrcA = 1, ALUSrcB = 0, PCSource = 1.
  - beq: ALUOp = 1, PCWrite = zero_i.
  - bne: ALUOp = 2, PCWrite = ~zero_i.
  - Next state FETCH.
- JUMP: PCWrite = 1, PCSource = 2. Next state FETCH.
- Wait counter (active in FETCH, MEM_RD, MEM_WR):
  - Increments each cycle mem_ready_i = 0; cleared on state exit.
  - If WAIT_LIMIT ≠ 0, the count reaches WAIT_LIMIT, and mem_ready_i is still 0: mem_err_o = 1 for that cycle, no IRWrite/PCWrite/RegWrite, next state FETCH.
  - mem_ready_i arriving on the limit cycle wins; no error is raised.
- Latency with zero-wait memory, counted from FETCH entry:
  - R/I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne/j: 3 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset for 2 cycles, release, mem_ready_i = 1 → state_o = 0, then 1, 6, 7, 0 for op 0x00; ALUOp_o = 0 in EXEC; RegWrite_o = 1 and RegDst_o = 1 in ALU_WB.
- lw (0x23) with mem_ready_i low for 3 cycles in MEM_RD → MEM_RD held 4 cycles with IorD_o = 1; MEM_WB has MemtoReg_o = 1; total 8 cycles.
- beq with zero_i = 1 → PCWrite_o = 1, PCSource_o = 1, ALUOp_o = 1. bne with zero_i = 1 → PCWrite_o = 0, ALUOp_o = 2.
- ori (0x0D) and lui (0x0F) → EXEC ALUOp_o = 5 and 6 respectively, ALUSrcB_o = 2; ALU_WB RegDst_o = 0.
- op_i = 0x3F in DECODE → illegal_o high exactly 1 cycle, next state_o = 0, no write strobes.
- WAIT_LIMIT = 4, sw (0x2B) with mem_ready_i never asserted → mem_err_o pulses on the 4th MEM_WR cycle, then FETCH. Separately, rst_i asserted mid-FETCH wait → MemRead_o = 0 in the same cycle and state_o = 0 after the next edge.
